// File: rtl/stream_checker_if.sv
// Bundle between the stream_checker and whatever feeds it: table load port, run control, byte stream and results.
interface stream_checker_if #(
   parameter int AW = 6
);
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic          start;
   logic          in_valid;
   logic [7:0]    in_byte;
   logic          busy;
   logic          done;
   logic          ok;
   logic [AW-1:0] match_cnt;
   logic [AW-1:0] err_idx;
   logic [7:0]    err_byte;

   modport master (
      output wr_en, wr_addr, wr_data, start, in_valid, in_byte,
      input  busy, done, ok, match_cnt, err_idx, err_byte
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, start, in_valid, in_byte,
      output busy, done, ok, match_cnt, err_idx, err_byte
   );
endinterface

// File: rtl/stream_checker.sv
// Compares LEN streamed bytes against a loadable expected table; done/busy update one cycle after the last byte, no backpressure.
// Define STREAM_CHECKER_ERRCAP_EN to capture index and byte of the first mismatch (otherwise err_* read 0).
module stream_checker #(
   parameter int LEN = 32,
   parameter int AW  = 6
) (
   input logic             clk,
   input logic             rst,
   stream_checker_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state;
   logic [AW-1:0] idx;
   logic [AW-1:0] match_cnt;
   logic          ok_r;
   logic          busy_r;
   logic          done_r;
   // Sized to the full index space so idx selects need no truncation; entries >= LEN are never written.
   logic [7:0]    tbl [2**AW];
   logic          hit;
   logic          start_run;
   logic          tbl_wr;

   assign hit       = (bus.in_byte == tbl[idx]);
   assign start_run = (state != RUN) && bus.start;
   assign tbl_wr    = (state != RUN) && bus.wr_en && (int'(bus.wr_addr) < LEN);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         idx       <= '0;
         match_cnt <= '0;
         ok_r      <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         for (int i = 0; i < 2**AW; i++) begin
            tbl[i] <= '0;
         end
      end else begin
         if (tbl_wr) begin
            tbl[bus.wr_addr] <= bus.wr_data;
         end
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  state     <= RUN;
                  idx       <= '0;
                  match_cnt <= '0;
                  ok_r      <= 1'b1;
                  busy_r    <= 1'b1;
                  done_r    <= 1'b0;
               end
            end
            RUN: begin
               if (bus.in_valid) begin
                  if (hit) begin
                     match_cnt <= match_cnt + 1'b1;
                  end else begin
                     ok_r <= 1'b0;
                  end
                  if (idx == AW'(LEN - 1)) begin
                     state  <= DONE;
                     busy_r <= 1'b0;
                     done_r <= 1'b1;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef STREAM_CHECKER_ERRCAP_EN
   logic [AW-1:0] err_idx_r;
   logic [7:0]    err_byte_r;

   // ok_r is still high only until the first mismatch of the run lands.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_idx_r  <= '0;
         err_byte_r <= '0;
      end else if (start_run) begin
         err_idx_r  <= '0;
         err_byte_r <= '0;
      end else if ((state == RUN) && bus.in_valid && !hit && ok_r) begin
         err_idx_r  <= idx;
         err_byte_r <= bus.in_byte;
      end
   end

   assign bus.err_idx  = err_idx_r;
   assign bus.err_byte = err_byte_r;
`else
   assign bus.err_idx  = '0;
   assign bus.err_byte = '0;
`endif

   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.ok        = done_r & ok_r;
   assign bus.match_cnt = match_cnt;

endmodule

// File: tb/tb_stream_checker.sv
// Randomised scoreboard bench for stream_checker: driver pushes expected run results, a negedge monitor pops them on done.
module tb_stream_checker;
   localparam int LEN = 32;
   localparam int AW  = 6;

   typedef struct {
      logic   ok;
      int     mc;
      int     eidx;
      int     ebyte;
      longint dcyc;
   } exp_t;

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   longint cyc = 0;
   int     n_cmp = 0;
   int     n_err = 0;

   exp_t       exp_q [$];
   logic [7:0] mtbl  [LEN];
   logic [7:0] base  [LEN];
   logic [7:0] stim  [LEN];
   int         gap   [LEN];
   bit         running = 1'b0;
   int         rst_at, mid_wr_at;
   bit         sw_en;
   int         sw_addr;
   logic [7:0] sw_data;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   stream_checker_if #(.AW(AW)) bus ();
   stream_checker #(.LEN(LEN), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

   function automatic void chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   // Reference: count equal positions, locate the first unequal one.
   function automatic exp_t model(input logic [7:0] t [LEN]);
      exp_t e;
      bit   seen;
      e.mc = 0; e.eidx = 0; e.ebyte = 0; e.dcyc = 0; seen = 1'b0;
      for (int i = 0; i < LEN; i++) begin
         if (stim[i] == t[i]) e.mc++;
         else if (!seen) begin
            seen = 1'b1;
`ifdef STREAM_CHECKER_ERRCAP_EN
            e.eidx  = i;
            e.ebyte = stim[i];
`endif
         end
      end
      e.ok = (e.mc == LEN);
      return e;
   endfunction

   task automatic clear_opts();
      rst_at = -1; mid_wr_at = -1; sw_en = 1'b0; sw_addr = 0; sw_data = 8'h00;
      for (int i = 0; i < LEN; i++) gap[i] = 0;
   endtask

   task automatic wr(input int a, input logic [7:0] d);
      bus.wr_en = 1'b1; bus.wr_addr = AW'(a); bus.wr_data = d;
      if (!running && a < LEN) mtbl[a] = d;
      @(negedge clk);
      bus.wr_en = 1'b0;
   endtask

   task automatic do_run();
      exp_t       e;
      logic [7:0] snap [LEN];
      bus.start = 1'b1;
      if (sw_en) begin
         bus.wr_en = 1'b1; bus.wr_addr = AW'(sw_addr); bus.wr_data = sw_data;
         if (sw_addr < LEN) mtbl[sw_addr] = sw_data;
      end
      snap = mtbl;
      @(negedge clk);
      bus.start = 1'b0; bus.wr_en = 1'b0; running = 1'b1;
      chk("busy_after_start", bus.busy, 1);
      chk("done_after_start", bus.done, 0);
      for (int i = 0; i < LEN; i++) begin
         bus.in_valid = 1'b1; bus.in_byte = stim[i];
         if (i == mid_wr_at) begin
            bus.wr_en = 1'b1; bus.wr_addr = AW'(3); bus.wr_data = 8'h00; bus.start = 1'b1;
         end
         if (i == rst_at) begin
            #2 rst = 1'b0;
            #1;
            chk("rst_busy", bus.busy, 0);
            chk("rst_done", bus.done, 0);
            chk("rst_ok", bus.ok, 0);
            chk("rst_match_cnt", bus.match_cnt, 0);
            chk("rst_err_idx", bus.err_idx, 0);
            chk("rst_err_byte", bus.err_byte, 0);
            @(negedge clk);
            bus.in_valid = 1'b0; bus.wr_en = 1'b0; bus.start = 1'b0;
            rst = 1'b1;
            for (int k = 0; k < LEN; k++) mtbl[k] = 8'h00;
            running = 1'b0;
            return;
         end
         if (i == LEN - 1) begin
            e = model(snap);
            e.dcyc = cyc + 1;
            exp_q.push_back(e);
         end
         @(negedge clk);
         bus.in_valid = 1'b0; bus.wr_en = 1'b0; bus.start = 1'b0;
         bus.in_byte = 8'($urandom);
         repeat (gap[i]) @(negedge clk);
      end
      running = 1'b0;
   endtask

   // Monitor: every rising done must match the oldest outstanding expectation.
   initial begin
      logic pd;
      exp_t e;
      pd = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.done && !pd) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("ok", bus.ok, e.ok);
               chk("match_cnt", bus.match_cnt, e.mc);
               chk("err_idx", bus.err_idx, e.eidx);
               chk("err_byte", bus.err_byte, e.ebyte);
               chk("busy_at_done", bus.busy, 0);
               chk("done_cycle", cyc, e.dcyc);
            end
         end
         pd = bus.done;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] tmp [LEN];
      bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
      bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_byte = '0;
      clear_opts();
      for (int i = 0; i < LEN; i++) mtbl[i] = 8'h00;
      #2 rst = 1'b0;
      @(negedge clk);
      chk("reset_busy", bus.busy, 0);
      chk("reset_done", bus.done, 0);
      chk("reset_ok", bus.ok, 0);
      chk("reset_match_cnt", bus.match_cnt, 0);
      chk("reset_err_idx", bus.err_idx, 0);
      chk("reset_err_byte", bus.err_byte, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < LEN; i++) base[i] = 8'($urandom_range(1, 255));
      base[0] = 8'd182; base[1] = 8'd199; base[2] = 8'd159; base[3] = 8'd225;
      base[5] = 8'd6;   base[30] = 8'd248; base[31] = 8'd215;
      for (int i = 0; i < LEN; i++) wr(i, base[i]);
      wr(40, 8'h55);
      wr(LEN, 8'h66);

      stim = base; do_run();
      stim = base; stim[5] = 8'd7; stim[20] = 8'd0; do_run();
      stim = base; gap[0] = 3; gap[10] = 3; gap[LEN-2] = 3; do_run();
      clear_opts();
      stim = base; do_run();

      stim = base; rst_at = 15; do_run();
      clear_opts();
      @(negedge clk);
      for (int i = 0; i < LEN; i++) stim[i] = 8'h00;
      do_run();
      stim = base; do_run();

      for (int i = 0; i < LEN; i++) wr(i, base[i]);
      wr(40, 8'h00);
      stim = base; mid_wr_at = 10; do_run();
      clear_opts();
      stim = base; do_run();

      repeat (6) begin
         clear_opts();
         repeat ($urandom_range(0, 8)) wr($urandom_range(0, 63), 8'($urandom));
         if ($urandom_range(0, 1) == 1) begin
            sw_en = 1'b1; sw_addr = $urandom_range(0, LEN - 1); sw_data = 8'($urandom);
         end
         tmp = mtbl;
         if (sw_en) tmp[sw_addr] = sw_data;
         for (int i = 0; i < LEN; i++) begin
            stim[i] = tmp[i];
            if ($urandom_range(0, 3) == 0) stim[i] = tmp[i] ^ 8'($urandom_range(1, 255));
            gap[i] = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0;
         end
         do_run();
      end

      repeat (4) @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/stream_checker.md
Name: stream_checker

Overview:
- Receive end of the per-cycle byte-transform stream produced by the challenge datapath.
- Holds a loadable table of expected bytes and consumes one transformed byte per valid cycle, comparing each against the table entry at the running index.
- Reports pass/fail, match count and first-mismatch information once LEN bytes have been consumed.
- Moves the compare loop from the bench into hardware so it can run on FPGA.

Parameters:
- LEN, 32, number of bytes per check run (legal range 1..63)
- AW, 6, index and counter width; must satisfy 2^AW > LEN

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active-low; clk and rst are the clock and reset ports, reset is asynchronous and active-low
- wr_en  input  1  write one expected-table entry
- wr_addr  input  AW  table index
- wr_data  input  8  expected byte
- start  input  1  begin a run
- in_valid  input  1  in_byte valid this cycle
- in_byte  input  8  transformed byte from datapath
- busy  output  1  run in progress
- done  output  1  run complete, results valid
- ok  output  1  all LEN bytes matched
- match_cnt  output  AW  number of matching bytes in the run
- err_idx  output  AW  index of first mismatch (see Optional Feature)
- err_byte  output  8  received byte at first mismatch (see Optional Feature)

Behaviour:
- Reset (rst low, async): FSM=IDLE, idx=0, all table entries=0. Outputs: busy=0, done=0, ok=0, match_cnt=0, err_idx=0, err_byte=0.
- Reset mid-run aborts the run and clears everything, table included.
- FSM IDLE:
  - start=1 -> RUN; idx=0, match_cnt=0, ok=1 (internal running flag), done=0, err fields=0.
  - in_valid is ignored.
- FSM RUN:
  - busy=1.
  - Each cycle with in_valid=1: compare in_byte against tbl[idx]. On equal, match_cnt+1. On unequal, ok<=0.
  - idx advances on every valid byte. Gaps (in_valid=0) hold all state.
  - Valid byte at idx==LEN-1 -> DONE on the next edge; busy drops and done rises one cycle after the last accepted byte.
  - start is ignored while in RUN.
- FSM DONE:
  - done=1 (level); ok, match_cnt, err_* are stable.
  - in_valid is ignored.
  - start=1 -> RUN with the same initialisation as IDLE, back-to-back allowed.
- Outputs:
  - ok reads 0 unless done=1 (output ok = done & ok_r).
  - match_cnt counts live during RUN.
- Table writes:
  - Accepted in IDLE and DONE only; ignored in RUN, so the table is frozen during a run.
  - wr_addr >= LEN is ignored.
  - A write and start in the same cycle: the write lands first, and the run uses the new value.
- Arithmetic:
  - Compare is an exact 8-bit equality.
  - match_cnt never exceeds LEN and does not wrap.
  - idx never exceeds LEN-1.
- All outputs are registered; there is no combinational path from in_byte to any output.

Optional Feature:
- Macro: STREAM_CHECKER_ERRCAP_EN
- Defined:
  - On the first mismatch of a run, capture err_idx=idx and err_byte=in_byte.
  - Later mismatches do not overwrite the captured values.
  - Both fields are cleared by start and by reset.
- Undefined:
  - err_idx and err_byte are tied to 0.
  - No capture registers are synthesised.

Test Plan:
- Load table with {182,199,159,225,...,248,215} (32 entries), start, stream the 32 identical bytes one per cycle -> done=1 exactly 1 cycle after byte 31, ok=1, match_cnt=32, busy=0.
- Same table, stream with byte 5 = 7 instead of 6 and byte 20 = 0 -> ok=0, match_cnt=30. With ERRCAP_EN: err_idx=5, err_byte=7. Without it: err_idx=0, err_byte=0.
- Correct stream with in_valid deasserted for 3 cycles after bytes 0, 10 and 31-1 -> ok=1, match_cnt=32; done timing measured from the last valid byte.
- Pull rst low for one cycle at byte 15 of a run -> all outputs 0 immediately (async). Then start a run without reloading: an all-zero stream gives ok=1, while the original stream gives ok=0.
- During RUN, issue wr_en addr 3 data 0 and also start=1 -> the run result is unaffected (ok=1 for a correct stream), and a post-run readback via a second run confirms tbl[3]=225.
- From DONE, issue start the cycle after done, then a correct stream -> done drops, busy=1, and the second run completes ok=1. wr_addr=40 writes are ignored.
